dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache controller on the MEM-stage side of the EX/MEM pipeline register. It consumes the registered MemRead/MemWrite/address/write-data outputs of EX/MEM. It returns load data, and raises a stall that holds EX/MEM and the earlier stages until a miss is serviced. Misses are serviced over a 256-bit request/acknowledge interface to off-chip data memory.

## Interface
- NUM_LINES, 16, number of cache lines (index width = log2).
- LINE_BITS, 256, line size in bits (32 bytes, 8 words).
- ADDR_W, 32, byte address width.
- clk_i  in  1  single clock, all state on rising edge.
- start_i  in  1  reset; synchronous, active-low.
- cpu_MemRead_i  in  1  load request, from EX/MEM.
- cpu_MemWrite_i  in  1  store request, from EX/MEM.
- cpu_addr_i  in  32  byte address (ALU result), word-aligned.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data.
- cpu_stall_o  out  1  hold pipeline; drives EX/MEM enable and upstream hazard logic.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = line write-back, 0 = line fill.
- mem_addr_o  out  32  line-aligned byte address.
- mem_wdata_o  out  256  write-back line.
- mem_rdata_i  in  256  fill line, valid with mem_ack_i.
- mem_ack_i  in  1  single-cycle completion pulse.

## Operation
- Address split: offset [4:0], word select [4:2], index [8:5], tag [31:9] (23 bits).
- Per-line state: valid, dirty, tag, 256-bit data.
- hit = request & valid[index] & (tag[index] == addr tag); request = MemRead | MemWrite.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: cpu_stall_o = 0, no state change.
- IDLE, hit:
  - cpu_stall_o = 0.
  - Load: cpu_rdata_o is the selected word, combinational, in the same cycle.
  - Store: the selected word is replaced at the clock edge and dirty is set.
- IDLE, miss: cpu_stall_o = 1. If valid & dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - mem_req_o = 1, mem_we_o = 1.
  - mem_addr_o = {old tag, index, 5'b0}; mem_wdata_o = old line.
  - On mem_ack_i, go to ALLOCATE.
- ALLOCATE:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i: line = mem_rdata_i, tag updated, valid = 1, dirty = 0, go to IDLE.
  - The access then hits in IDLE (replay).
- cpu_stall_o = request & ~(state == IDLE & hit). Combinational.
- cpu_rdata_o = selected word when hit, else 32'b0.
- Both MemRead and MemWrite asserted: treated as a store; cpu_rdata_o still shows the pre-store word.
- mem_ack_i while mem_req_o = 0 is ignored.

## Timing
- Reset (start_i = 0 at an edge):
  - state = IDLE; all valid and dirty bits cleared.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - cpu_stall_o = 0 and cpu_rdata_o = 0 while no request.
  - Data and tag arrays are not cleared.
- Reset mid-operation abandons any memory transaction (mem_req_o is low the next cycle) and discards dirty data.
- Hit latency: 0 stall cycles.
- Clean miss detected in cycle 0:
  - ALLOCATE is entered at cycle 1 and mem_req_o rises there.
  - mem_ack_i arrives at cycle k; the fill is written at the end of k.
  - IDLE hit at k+1, where cpu_stall_o falls.
- Dirty miss: WRITEBACK from cycle 1 until ack at cycle j, then ALLOCATE from j+1 until ack at k; stall drops at k+1.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered. They stay stable from the first request cycle through the ack cycle.
- mem_req_o deasserts the cycle after ack, or stays high with new address/we on the WRITEBACK→ALLOCATE transition.
- Inputs from EX/MEM are stable during stall because EX/MEM holds on cpu_stall_o.

## Structure
- Package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, ALLOCATE);
  - the OFFSET_W/INDEX_W/TAG_W constants and field-slice localparams;
  - the LINE_BITS default.
- Sub-module dcache_sram: tag/valid/dirty/data arrays.
  - Combinational read port on index.
  - One write port (full-line fill or single-word store with dirty set).
  - Synchronous clear of valid and dirty on reset.
- The controller holds the FSM, hit logic, and memory-interface registers.

## Test plan
- Reset, then load 0x0000_0040 with memory latency 10 → mem_req_o=1, mem_we_o=0, mem_addr_o=0x40; stall held through ack; next cycle stall=0 and cpu_rdata_o = word 0 of the fill line.
- Store 0xDEADBEEF to 0x44 after the fill, then load 0x44 → both 0 stall cycles; load returns 0xDEADBEEF; dirty[2]=1.
- Load 0x244 (same index 2, tag 1) with line 2 dirty → WRITEBACK to 0x40 with word 1 = 0xDEADBEEF, then ALLOCATE 0x240; stall falls the cycle after the second ack.
- Miss to a clean line → no write-back; exactly one request with mem_we_o=0.
- start_i low during ALLOCATE before ack → mem_req_o=0 next cycle; all lines invalid; re-load of 0x40 misses again.
- Spurious mem_ack_i in IDLE and both MemRead/MemWrite high on a hit → no state change from the ack; behaves as a store.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared constants, address-field layout and FSM state type for the L1 data cache.
package dcache_pkg;

    localparam int NUM_LINES = 16;
    localparam int LINE_BITS = 256;
    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int WORDS     = LINE_BITS / WORD_W;

    // Byte address = {tag, index, word select, byte offset}
    localparam int OFFSET_W  = 5;
    localparam int INDEX_W   = $clog2(NUM_LINES);
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WSEL_W    = $clog2(WORDS);
    localparam int WSEL_LSB  = 2;
    localparam int INDEX_LSB = OFFSET_W;
    localparam int TAG_LSB   = OFFSET_W + INDEX_W;

    typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_e;

endpackage

// File: rtl/dcache_if.sv
// Line-wide request/acknowledge bus between the cache and off-chip data memory.
interface dcache_if;
    import dcache_pkg::*;

    logic                 req;
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_BITS-1:0] wdata;
    logic [LINE_BITS-1:0] rdata;
    logic                 ack;

    modport master (output req, output we, output addr, output wdata,
                    input rdata, input ack);
    modport slave  (input req, input we, input addr, input wdata,
                    output rdata, output ack);

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read, one write port (fill or word store).
module dcache_sram
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               start_i,
    input  logic [INDEX_W-1:0] index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output line_t              rd_line,
    input  logic               wr_fill,
    input  logic               wr_store,
    input  logic [TAG_W-1:0]   wr_tag,
    input  line_t              wr_line,
    input  logic [WSEL_W-1:0]  wr_sel,
    input  logic [WORD_W-1:0]  wr_word
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_line  = data_q[index];

    // Line status bits: cleared by reset, set by fill (clean) or store (dirty).
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_fill) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (wr_store) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Tag and data payload: never reset, invalid lines are masked by valid_q.
    always_ff @(posedge clk_i) begin
        if (wr_fill) begin
            tag_q[index]  <= wr_tag;
            data_q[index] <= wr_line;
        end else if (wr_store) begin
            data_q[index][wr_sel] <= wr_word;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller at the MEM stage.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_wdata_i,
    output logic [WORD_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    dcache_if.master          mem
);

    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   req_tag;
    logic [WSEL_W-1:0]  word_sel;
    logic               rd_valid, rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    line_t              rd_line;
    logic               request, hit, fill_en, store_en;
    logic               unused_byte_bits;

    assign index            = cpu_addr_i[INDEX_LSB +: INDEX_W];
    assign req_tag          = cpu_addr_i[TAG_LSB +: TAG_W];
    assign word_sel         = cpu_addr_i[WSEL_LSB +: WSEL_W];
    assign unused_byte_bits = ^cpu_addr_i[1:0];

    assign request     = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit         = request & rd_valid & (rd_tag == req_tag);
    assign cpu_stall_o = request & ~((state_q == S_IDLE) & hit);
    assign cpu_rdata_o = hit ? rd_line[word_sel] : '0;
    assign store_en    = (state_q == S_IDLE) & hit & cpu_MemWrite_i;

    assign mem.req   = req_q;
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    dcache_sram u_sram (
        .clk_i    (clk_i),
        .start_i  (start_i),
        .index    (index),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_fill  (fill_en),
        .wr_store (store_en),
        .wr_tag   (req_tag),
        .wr_line  (line_t'(mem.rdata)),
        .wr_sel   (word_sel),
        .wr_word  (cpu_wdata_i)
    );

    // FSM state and registered memory-bus outputs; reset abandons any transaction.
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state, next bus values and fill strobe; ack only matters while a request is open.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fill_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (request && !hit) begin
                    req_d = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d = S_WRITEBACK;
                        we_d    = 1'b1;
                        addr_d  = {rd_tag, index, {OFFSET_W{1'b0}}};
                        wdata_d = rd_line;
                    end else begin
                        state_d = S_ALLOCATE;
                        we_d    = 1'b0;
                        addr_d  = {req_tag, index, {OFFSET_W{1'b0}}};
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem.ack) begin
                    state_d = S_ALLOCATE;
                    we_d    = 1'b0;
                    addr_d  = {req_tag, index, {OFFSET_W{1'b0}}};
                end
            end
            S_ALLOCATE: begin
                if (mem.ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    fill_en = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: fills, stores, write-back, reset abort, spurious ack.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         start_i;
    logic         cpu_MemRead_i, cpu_MemWrite_i;
    logic [31:0]  cpu_addr_i, cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;

    int checks = 0;
    int errors = 0;

    dcache_if mem_bus ();

    dcache_controller dut (
        .clk_i          (clk_i),
        .start_i        (start_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_wdata_i    (cpu_wdata_i),
        .cpu_rdata_o    (cpu_rdata_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem            (mem_bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check an open request, hold it for lat cycles, then ack with the given fill line.
    task automatic serve(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                         input logic chk_wd, input logic [255:0] exp_wd,
                         input int lat, input logic [255:0] line);
        chk({tag, "_req"}, 256'(mem_bus.req), 256'd1);
        chk({tag, "_we"}, 256'(mem_bus.we), 256'(exp_we));
        chk({tag, "_addr"}, 256'(mem_bus.addr), 256'(exp_addr));
        if (chk_wd) chk({tag, "_wdata"}, mem_bus.wdata, exp_wd);
        for (int c = 1; c < lat; c++) begin
            tick();
            chk({tag, "_stall_hold"}, 256'(cpu_stall_o), 256'd1);
            chk({tag, "_addr_stable"}, 256'(mem_bus.addr), 256'(exp_addr));
        end
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = line;
        #1;
        chk({tag, "_stall_at_ack"}, 256'(cpu_stall_o), 256'd1);
        tick();
        mem_bus.ack = 1'b0;
        #1;
    endtask

    logic [255:0] line_a, line_b, line_c, line_d, exp_wb;

    initial begin
        line_a = mk_line(32'hA000_0000);
        line_b = mk_line(32'hB000_0000);
        line_c = mk_line(32'hC000_0000);
        line_d = mk_line(32'hD000_0000);

        start_i        = 1'b0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        cpu_addr_i     = 32'h0;
        cpu_wdata_i    = 32'h0;
        mem_bus.ack    = 1'b0;
        mem_bus.rdata  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_req", 256'(mem_bus.req), 256'd0);
        chk("rst_we", 256'(mem_bus.we), 256'd0);
        chk("rst_addr", 256'(mem_bus.addr), 256'd0);
        chk("rst_wdata", mem_bus.wdata, 256'd0);
        chk("rst_stall", 256'(cpu_stall_o), 256'd0);
        chk("rst_rdata", 256'(cpu_rdata_o), 256'd0);
        start_i = 1'b1;
        tick();

        // Cold load of 0x40: clean miss, ALLOCATE with latency 10
        cpu_MemRead_i = 1'b1;
        cpu_addr_i    = 32'h0000_0040;
        #1;
        chk("ld40_stall_c0", 256'(cpu_stall_o), 256'd1);
        chk("ld40_req_c0", 256'(mem_bus.req), 256'd0);
        tick();
        serve("ld40", 1'b0, 32'h40, 1'b0, '0, 10, line_a);
        chk("ld40_stall_done", 256'(cpu_stall_o), 256'd0);
        chk("ld40_rdata", 256'(cpu_rdata_o), 256'h A000_0000);
        chk("ld40_req_done", 256'(mem_bus.req), 256'd0);

        // Store hit to 0x44, then load it back
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b1;
        cpu_addr_i     = 32'h0000_0044;
        cpu_wdata_i    = 32'hDEAD_BEEF;
        #1;
        chk("st44_stall", 256'(cpu_stall_o), 256'd0);
        tick();
        cpu_MemWrite_i = 1'b0;
        cpu_MemRead_i  = 1'b1;
        #1;
        chk("ld44_stall", 256'(cpu_stall_o), 256'd0);
        chk("ld44_rdata", 256'(cpu_rdata_o), 256'h DEAD_BEEF);
        chk("dirty2", 256'(dut.u_sram.dirty_q[2]), 256'd1);

        // Conflict load of 0x244: dirty line 2 written back, then refilled
        cpu_addr_i = 32'h0000_0244;
        #1;
        chk("ld244_stall_c0", 256'(cpu_stall_o), 256'd1);
        chk("ld244_rdata_miss", 256'(cpu_rdata_o), 256'd0);
        tick();
        exp_wb = line_a;
        exp_wb[63:32] = 32'hDEAD_BEEF;
        serve("wb40", 1'b1, 32'h40, 1'b1, exp_wb, 3, '0);
        serve("al240", 1'b0, 32'h240, 1'b0, '0, 4, line_b);
        chk("ld244_stall_done", 256'(cpu_stall_o), 256'd0);
        chk("ld244_rdata", 256'(cpu_rdata_o), 256'h B000_0001);
        chk("ld244_req_done", 256'(mem_bus.req), 256'd0);

        // Miss to a valid clean line: straight to ALLOCATE, single read request
        cpu_addr_i = 32'h0000_0440;
        #1;
        chk("ld440_stall_c0", 256'(cpu_stall_o), 256'd1);
        tick();
        serve("al440", 1'b0, 32'h440, 1'b0, '0, 2, line_d);
        chk("ld440_rdata", 256'(cpu_rdata_o), 256'h D000_0000);
        tick();
        chk("ld440_no_second_req", 256'(mem_bus.req), 256'd0);

        // Miss to an invalid line
        cpu_addr_i = 32'h0000_0080;
        tick();
        serve("al80", 1'b0, 32'h80, 1'b0, '0, 2, line_c);
        chk("ld80_rdata", 256'(cpu_rdata_o), 256'h C000_0000);

        // Spurious ack while idle with no request
        cpu_MemRead_i = 1'b0;
        mem_bus.ack   = 1'b1;
        tick();
        mem_bus.ack = 1'b0;
        #1;
        chk("spur_req", 256'(mem_bus.req), 256'd0);
        chk("spur_stall", 256'(cpu_stall_o), 256'd0);

        // Read and write together on a hit: store wins, read shows old word
        cpu_MemRead_i  = 1'b1;
        cpu_MemWrite_i = 1'b1;
        cpu_addr_i     = 32'h0000_0448;
        cpu_wdata_i    = 32'h1234_5678;
        #1;
        chk("rw_stall", 256'(cpu_stall_o), 256'd0);
        chk("rw_rdata_old", 256'(cpu_rdata_o), 256'h D000_0002);
        tick();
        cpu_MemWrite_i = 1'b0;
        #1;
        chk("rw_rdata_new", 256'(cpu_rdata_o), 256'h 1234_5678);
        chk("rw_dirty2", 256'(dut.u_sram.dirty_q[2]), 256'd1);

        // Reset in the middle of ALLOCATE
        cpu_addr_i = 32'h0000_0100;
        tick();
        chk("abort_req_open", 256'(mem_bus.req), 256'd1);
        tick();
        start_i = 1'b0;
        tick();
        chk("abort_req", 256'(mem_bus.req), 256'd0);
        chk("abort_valid", 256'(dut.u_sram.valid_q), 256'd0);
        chk("abort_dirty", 256'(dut.u_sram.dirty_q), 256'd0);
        start_i    = 1'b1;
        cpu_addr_i = 32'h0000_0040;
        #1;
        chk("reld40_stall", 256'(cpu_stall_o), 256'd1);
        chk("reld40_rdata", 256'(cpu_rdata_o), 256'd0);
        tick();
        serve("reld40", 1'b0, 32'h40, 1'b0, '0, 2, line_c);
        chk("reld40_rdata_done", 256'(cpu_rdata_o), 256'h C000_0000);
        cpu_MemRead_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
